shift_seq_ctrl: RTL and testbench

Multi-cycle shift sequencer for the EX stage of the pipelined CPU. It accepts one shift request at a time and performs a logarithmic shift iteratively, applying one power-of-two stage (16, 8, 4, 2, 1) per clock. It supports SLL, SRL and SRA, and drives a pipeline stall while a shift is in progress. It replaces the purely combinational shift path where timing requires a sequenced unit.

---
 rtl/shift_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Iterative logarithmic shifter for the EX stage. A request is
//                accepted in IDLE, one power-of-two stage (2^(SHW-1) .. 1) is
//                applied per clock, and the result is presented with a
//                one-cycle done pulse. Pipeline stall is held while shifting.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic             stall
);

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHW-1:0]     shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;

    logic [SHW-1:0]     w_amt;
    logic [WIDTH-1:0]   w_stage;

    // Shift applied by the current stage: 2^cnt in the latched direction.
    always_comb begin
        w_amt = SHW'(1) << cnt_q;
        case (op_q)
            c_OP_SLL: w_stage = acc_q << w_amt;
            c_OP_SRL: w_stage = acc_q >> w_amt;
            // Sign is preserved across stages, so acc MSB is the original sign.
            c_OP_SRA: w_stage = WIDTH'($signed(acc_q) >>> w_amt);
            default:  w_stage = acc_q;
        endcase
    end

    // Next-state, datapath update and flush override.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    acc_d   = dataA;
                    shamt_d = shamt;
                    op_d    = op;
                    cnt_d   = SHW'(SHW - 1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shamt_q[cnt_q]) begin
                    acc_d = w_stage;
                end
                if (cnt_q == '0) begin
                    dout_d  = acc_d;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // An aborted operation must never publish a result.
        if (flush) begin
            state_d = S_IDLE;
            dout_d  = dout_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // Status outputs are decoded from state; stall also covers the accept cycle.
    always_comb begin
        busy    = (state_q == S_SHIFT);
        done    = (state_q == S_DONE);
        dataOut = dout_q;
        stall   = (state_q == S_SHIFT) || ((state_q == S_IDLE) && start && !flush);
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl with a transaction
//                level reference model and directed plus random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [SHW-1:0]   shamt;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;
    logic             stall;

    int n_chk  = 0;
    int n_pass = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .dataA   (dataA),
        .shamt   (shamt),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    // Whole-operation result straight from the shift semantics.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] o,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [SHW-1:0] s);
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b11:   return WIDTH'($signed(a) >>> s);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    // Reference model: cycles elapsed since acceptance (0 = idle), result
    // computed in one step when the request is taken.
    int               m_age;
    logic [WIDTH-1:0] m_res;
    logic [WIDTH-1:0] m_dout;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age  = 0;
            m_dout = '0;
        end else if (flush) begin
            m_age = 0;
        end else if (m_age == 0) begin
            if (start) begin
                m_res = ref_shift(op, dataA, shamt);
                m_age = 1;
            end
        end else if (m_age == SHW) begin
            m_dout = m_res;
            m_age  = SHW + 1;
        end else if (m_age == SHW + 1) begin
            m_age = 0;
        end else begin
            m_age = m_age + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic e_busy, e_done, e_stall;
        e_busy  = (m_age >= 1) && (m_age <= SHW);
        e_done  = (m_age == SHW + 1);
        e_stall = e_busy || ((m_age == 0) && start && !flush);
        chk("busy",    WIDTH'(busy),  WIDTH'(e_busy));
        chk("done",    WIDTH'(done),  WIDTH'(e_done));
        chk("stall",   WIDTH'(stall), WIDTH'(e_stall));
        chk("dataOut", dataOut,       m_dout);
    end

    // Issue one request from IDLE and wait (bounded) for its done pulse.
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                          input logic [SHW-1:0] s, output int lat);
        start = 1'b1; op = o; dataA = a; shamt = s;
        @(posedge clk); #1;
        start = 1'b0;
        dataA = $urandom; shamt = SHW'($urandom); op = 2'($urandom);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                chk("stall_in_done", WIDTH'(stall), '0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int ndone;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; dataA = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    WIDTH'(busy),  '0);
        chk("rst_done",    WIDTH'(done),  '0);
        chk("rst_dataOut", dataOut,       '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // SLL 1 by 31, fixed latency.
        run_op(2'b00, 32'h0000_0001, 5'd31, lat);
        chk("sll31_lat", WIDTH'(lat), WIDTH'(SHW + 1));
        chk("sll31", dataOut, 32'h8000_0000);

        run_op(2'b11, 32'h8000_0000, 5'd4, lat);
        chk("sra_neg", dataOut, 32'hF800_0000);
        run_op(2'b01, 32'h8000_0000, 5'd4, lat);
        chk("srl", dataOut, 32'h0800_0000);
        run_op(2'b11, 32'h7FFF_FFF0, 5'd4, lat);
        chk("sra_pos", dataOut, 32'h07FF_FFFF);

        run_op(2'b00, 32'hDEAD_BEEF, 5'd0, lat);
        chk("zero_lat", WIDTH'(lat), WIDTH'(SHW + 1));
        chk("zero_shift", dataOut, 32'hDEAD_BEEF);
        run_op(2'b10, 32'hDEAD_BEEF, 5'd7, lat);
        chk("reserved_op", dataOut, 32'hDEAD_BEEF);

        // Start collision during SHIFT is ignored.
        start = 1'b1; op = 2'b00; dataA = 32'h0000_000F; shamt = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; dataA = 32'h1234_5678; shamt = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10 && ndone == 0; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("collision_done", WIDTH'(ndone), 1);
        chk("collision", dataOut, 32'h0000_0078);
        @(posedge clk); #1;

        // Flush at stage 3: no done, dataOut unchanged.
        start = 1'b1; op = 2'b00; dataA = 32'h0000_0001; shamt = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", WIDTH'(busy), '0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("flush_nodone", WIDTH'(ndone), '0);
        chk("flush_keep", dataOut, 32'h0000_0078);
        @(posedge clk); #1;

        // flush overrides start in IDLE.
        start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start_stall", WIDTH'(stall), '0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", WIDTH'(busy), '0);
        @(posedge clk); #1;

        // Asynchronous reset between edges during SHIFT.
        start = 1'b1; op = 2'b00; dataA = 32'h0000_00FF; shamt = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_busy",    WIDTH'(busy),  '0);
        chk("arst_done",    WIDTH'(done),  '0);
        chk("arst_dataOut", dataOut,       '0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(2'b01, 32'hFFFF_FFFF, 5'd16, lat);
        chk("post_reset_srl", dataOut, 32'h0000_FFFF);

        // Random traffic, including collisions and flushes.
        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 14) == 0);
            op    = 2'($urandom);
            dataA = $urandom;
            shamt = SHW'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
